timer_ctrl_core: RTL

- Parametrised successor to the monitor's stopwatch timer control FSM.
- Holds the minutes/seconds count registers itself and supports count-up and count-down modes, field editing with increment/decrement, pause/resume, clear, and a terminal-count alarm.
- Sits between the debounced button inputs and the VGA digit renderer.
- Advances only on an external 1 Hz tick strobe.

---
 rtl/timer_ctrl_core.sv | 264 ++++++++++++++++++++++++++
 1 files changed

// File: rtl/timer_ctrl_core.sv
// timer_ctrl_core
// Stopwatch/countdown control for the monitor display. Owns the minutes and
// seconds count registers, advances them on an external 1 Hz tick strobe,
// supports field editing, pause/resume, clear and a terminal-count alarm.
//
// Ports:
//   clk, rst_n            system clock, asynchronous active-low reset
//   tick                  one-cycle 1 Hz enable strobe
//   start, stop, clear    run control (clear > stop > start)
//   set_req, sel_next     enter edit mode / toggle edited field
//   inc, dec              edit the selected field by one (wrapping)
//   count_down            direction, latched when entering RUN
//   min_out, sec_out      current count
//   state_out             encoded state (IDLE=0 .. DONE=5)
//   running, edit_min,
//   edit_sec, alarm       registered status flags
module timer_ctrl_core #(
  parameter int MIN_W       = 7,
  parameter int SEC_W       = 6,
  parameter int MAX_MIN     = 99,
  parameter int MAX_SEC     = 59,
  parameter int ALARM_TICKS = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             tick,
  input  logic             start,
  input  logic             stop,
  input  logic             clear,
  input  logic             set_req,
  input  logic             sel_next,
  input  logic             inc,
  input  logic             dec,
  input  logic             count_down,
  output logic [MIN_W-1:0] min_out,
  output logic [SEC_W-1:0] sec_out,
  output logic [2:0]       state_out,
  output logic             running,
  output logic             edit_min,
  output logic             edit_sec,
  output logic             alarm
);

  localparam int CNT_W = (ALARM_TICKS < 1) ? 1 : $clog2(ALARM_TICKS + 1);

  localparam logic [MIN_W-1:0] MIN_MAX  = MIN_W'(MAX_MIN);
  localparam logic [MIN_W-1:0] MIN_ZERO = {MIN_W{1'b0}};
  localparam logic [MIN_W-1:0] MIN_ONE  = MIN_W'(1);
  localparam logic [SEC_W-1:0] SEC_MAX  = SEC_W'(MAX_SEC);
  localparam logic [SEC_W-1:0] SEC_ZERO = {SEC_W{1'b0}};
  localparam logic [SEC_W-1:0] SEC_ONE  = SEC_W'(1);
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(ALARM_TICKS);
  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic             ALARM_ON = (ALARM_TICKS > 0) ? 1'b1 : 1'b0;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_SET_MIN = 3'd1,
    ST_SET_SEC = 3'd2,
    ST_RUN     = 3'd3,
    ST_PAUSE   = 3'd4,
    ST_DONE    = 3'd5
  } state_t;

  typedef enum logic [2:0] {
    CMD_NONE  = 3'd0,
    CMD_STOP  = 3'd1,
    CMD_START = 3'd2,
    CMD_SET   = 3'd3,
    CMD_SEL   = 3'd4,
    CMD_INC   = 3'd5,
    CMD_DEC   = 3'd6
  } cmd_t;

  state_t           state_r, state_s;
  cmd_t             cmd_s;
  logic [MIN_W-1:0] min_r, min_s, min_inc_s, min_dec_s, min_up_s, min_dn_s;
  logic [SEC_W-1:0] sec_r, sec_s, sec_inc_s, sec_dec_s;
  logic [CNT_W-1:0] alarm_cnt_r, alarm_cnt_s;
  logic             dir_r, dir_s, alarm_r, alarm_s;
  logic             running_r, edit_min_r, edit_sec_r;
  logic             zero_s, start_ok_s, at_top_s, dn_zero_s;

  // Wrapping field arithmetic, compared against the parameter limits.
  assign min_inc_s  = (min_r >= MIN_MAX)  ? MIN_ZERO : min_r + MIN_ONE;
  assign min_dec_s  = (min_r == MIN_ZERO) ? MIN_MAX  : min_r - MIN_ONE;
  assign sec_inc_s  = (sec_r >= SEC_MAX)  ? SEC_ZERO : sec_r + SEC_ONE;
  assign sec_dec_s  = (sec_r == SEC_ZERO) ? SEC_MAX  : sec_r - SEC_ONE;
  // Run-mode carries/borrows between the fields.
  assign min_up_s   = (sec_r >= SEC_MAX)  ? min_inc_s : min_r;
  assign min_dn_s   = (sec_r == SEC_ZERO) ? min_dec_s : min_r;
  assign zero_s     = (min_r == MIN_ZERO) && (sec_r == SEC_ZERO);
  assign at_top_s   = (min_r >= MIN_MAX) && (sec_r >= SEC_MAX);
  assign dn_zero_s  = (min_dn_s == MIN_ZERO) && (sec_dec_s == SEC_ZERO);
  // A countdown from 00:00 would underflow, so such a start is refused.
  assign start_ok_s = ~(count_down & zero_s);

  // Resolve simultaneous button requests to the single highest-priority one.
  always_comb begin
    cmd_s = CMD_NONE;
    if (stop) begin
      cmd_s = CMD_STOP;
    end else if (start) begin
      cmd_s = CMD_START;
    end else if (set_req) begin
      cmd_s = CMD_SET;
    end else if (sel_next) begin
      cmd_s = CMD_SEL;
    end else if (inc) begin
      cmd_s = CMD_INC;
    end else if (dec) begin
      cmd_s = CMD_DEC;
    end else begin
      cmd_s = CMD_NONE;
    end
  end

  // Next-state and next-count logic.
  always_comb begin
    state_s     = state_r;
    min_s       = min_r;
    sec_s       = sec_r;
    dir_s       = dir_r;
    alarm_s     = alarm_r;
    alarm_cnt_s = alarm_cnt_r;
    if (clear) begin
      state_s     = ST_IDLE;
      min_s       = MIN_ZERO;
      sec_s       = SEC_ZERO;
      alarm_s     = 1'b0;
      alarm_cnt_s = CNT_ZERO;
    end else begin
      case (state_r)
        ST_IDLE, ST_PAUSE: begin
          case (cmd_s)
            CMD_START: begin
              if (start_ok_s) begin
                state_s = ST_RUN;
                dir_s   = count_down;
              end else begin
                state_s = state_r;
              end
            end
            CMD_SET: state_s = ST_SET_MIN;
            default: state_s = state_r;
          endcase
        end
        ST_SET_MIN, ST_SET_SEC: begin
          case (cmd_s)
            CMD_START: begin
              if (start_ok_s) begin
                state_s = ST_RUN;
                dir_s   = count_down;
              end else begin
                state_s = state_r;
              end
            end
            CMD_SEL: state_s = (state_r == ST_SET_MIN) ? ST_SET_SEC : ST_SET_MIN;
            CMD_INC: begin
              if (state_r == ST_SET_MIN) begin
                min_s = min_inc_s;
              end else begin
                sec_s = sec_inc_s;
              end
            end
            CMD_DEC: begin
              if (state_r == ST_SET_MIN) begin
                min_s = min_dec_s;
              end else begin
                sec_s = sec_dec_s;
              end
            end
            default: state_s = state_r;
          endcase
        end
        ST_RUN: begin
          if (cmd_s == CMD_STOP) begin
            // Pausing wins over a coincident tick: the count freezes as is.
            state_s = ST_PAUSE;
          end else if (tick) begin
            if (dir_r) begin
              if (zero_s) begin
                state_s     = ST_DONE;
                alarm_s     = ALARM_ON;
                alarm_cnt_s = CNT_INIT;
              end else begin
                min_s = min_dn_s;
                sec_s = sec_dec_s;
                if (dn_zero_s) begin
                  state_s     = ST_DONE;
                  alarm_s     = ALARM_ON;
                  alarm_cnt_s = CNT_INIT;
                end else begin
                  state_s = ST_RUN;
                end
              end
            end else begin
              // Up mode saturates: the tick past the top holds the count.
              if (at_top_s) begin
                state_s     = ST_DONE;
                alarm_s     = ALARM_ON;
                alarm_cnt_s = CNT_INIT;
              end else begin
                min_s = min_up_s;
                sec_s = sec_inc_s;
              end
            end
          end else begin
            state_s = ST_RUN;
          end
        end
        ST_DONE: begin
          if ((cmd_s == CMD_START) || (cmd_s == CMD_STOP)) begin
            state_s     = ST_IDLE;
            alarm_s     = 1'b0;
            alarm_cnt_s = CNT_ZERO;
          end else if (tick && (alarm_cnt_r != CNT_ZERO)) begin
            alarm_cnt_s = alarm_cnt_r - CNT_ONE;
            alarm_s     = (alarm_cnt_r != CNT_ONE);
          end else begin
            state_s = ST_DONE;
          end
        end
        default: state_s = ST_IDLE;
      endcase
    end
  end

  // State, count and flag registers; flags track the next state so they
  // line up with state_out.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= ST_IDLE;
      min_r       <= MIN_ZERO;
      sec_r       <= SEC_ZERO;
      dir_r       <= 1'b0;
      alarm_r     <= 1'b0;
      alarm_cnt_r <= CNT_ZERO;
      running_r   <= 1'b0;
      edit_min_r  <= 1'b0;
      edit_sec_r  <= 1'b0;
    end else begin
      state_r     <= state_s;
      min_r       <= min_s;
      sec_r       <= sec_s;
      dir_r       <= dir_s;
      alarm_r     <= alarm_s;
      alarm_cnt_r <= alarm_cnt_s;
      running_r   <= (state_s == ST_RUN);
      edit_min_r  <= (state_s == ST_SET_MIN);
      edit_sec_r  <= (state_s == ST_SET_SEC);
    end
  end

  assign min_out   = min_r;
  assign sec_out   = sec_r;
  assign state_out = state_r;
  assign running   = running_r;
  assign edit_min  = edit_min_r;
  assign edit_sec  = edit_sec_r;
  assign alarm     = alarm_r;

endmodule
